dmem: RTL and testbench

Data-memory responder at the far end of the core's `dmem_*` port. Holds `DEPTH` full-width words, serves the core's combinational loads and single-cycle stores, and drives the shared `dmem_data` bus during loads. A second host port lets the testbench or a loader read, write or clear memory with valid/ready handshakes. Core stores always take priority over host traffic.

---
 rtl/dmem.sv | 127 ++++++++++++
 tb/tb_dmem.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem.sv
// Data memory for the core's dmem port, with a host port for read/write/clear.
// Core stores take priority over all host activity and are never stalled.
module dmem #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] dmem_addr,
    inout  wire  [XLEN-1:0] dmem_data,
    input  logic            dmem_wen,
    input  logic            host_req_valid,
    output logic            host_req_ready,
    input  logic [1:0]      host_req_op,
    input  logic [AW-1:0]   host_req_addr,
    input  logic [XLEN-1:0] host_req_wdata,
    output logic            host_rsp_valid,
    input  logic            host_rsp_ready,
    output logic [XLEN-1:0] host_rsp_data,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, CLEAR, RSP} state_t;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    logic [XLEN-1:0] mem [DEPTH];

    state_t          state, state_n;
    logic [AW-1:0]   ptr, ptr_n;
    logic [XLEN-1:0] rsp_n;
    logic            hw_en;
    logic [AW-1:0]   hw_idx;
    logic [XLEN-1:0] hw_data;
    logic            accept;

    logic [AW-1:0]   core_idx;
    logic            unused_addr_bits;

    assign core_idx         = dmem_addr[AW-1:0];
    assign unused_addr_bits = ^dmem_addr[XLEN-1:AW];

    assign dmem_data = dmem_wen ? {XLEN{1'bz}} : mem[core_idx];

    assign host_req_ready = (state == IDLE) & ~dmem_wen & ~reset;
    assign accept         = host_req_valid & host_req_ready;
    assign host_rsp_valid = (state == RSP);
    assign busy           = (state != IDLE);

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        rsp_n   = host_rsp_data;
        hw_en   = 1'b0;
        hw_idx  = ptr;
        hw_data = '0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (host_req_op)
                        OP_RD: begin
                            rsp_n   = mem[host_req_addr];
                            state_n = RSP;
                        end
                        OP_WR: begin
                            hw_en   = 1'b1;
                            hw_idx  = host_req_addr;
                            hw_data = host_req_wdata;
                            rsp_n   = host_req_wdata;
                            state_n = RSP;
                        end
                        OP_CLR: begin
                            ptr_n   = '0;
                            state_n = CLEAR;
                        end
                        OP_NOP: begin
                            rsp_n   = '0;
                            state_n = RSP;
                        end
                        default: state_n = IDLE;
                    endcase
                end
            end
            CLEAR: begin
                // A core store owns the write port; the sweep simply pauses.
                if (!dmem_wen) begin
                    hw_en = 1'b1;
                    ptr_n = ptr + AW'(1);
                    if (ptr == AW'(DEPTH - 1)) begin
                        rsp_n   = XLEN'(DEPTH);
                        state_n = RSP;
                    end
                end
            end
            RSP: begin
                if (host_rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= '0;
            host_rsp_data <= '0;
        end else begin
            state         <= state_n;
            ptr           <= ptr_n;
            host_rsp_data <= rsp_n;
        end
    end

    // Contents survive reset; reset only suppresses the clear sweep write.
    always_ff @(posedge clk) begin
        if (dmem_wen) begin
            mem[core_idx] <= dmem_data;
        end else if (hw_en && !reset) begin
            mem[hw_idx] <= hw_data;
        end
    end

endmodule

// File: tb/tb_dmem.sv
// Directed bench for dmem: core load/store table plus host-port sequences.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
module tb_dmem;

    logic        clk;
    logic        reset;
    logic [31:0] dmem_addr;
    wire  [31:0] dmem_data;
    logic        dmem_wen;
    logic [31:0] core_wdata;
    logic        host_req_valid;
    logic        host_req_ready;
    logic [1:0]  host_req_op;
    logic [4:0]  host_req_addr;
    logic [31:0] host_req_wdata;
    logic        host_rsp_valid;
    logic        host_rsp_ready;
    logic [31:0] host_rsp_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    assign dmem_data = dmem_wen ? core_wdata : 32'hzzzz_zzzz;

    dmem dut (
        .clk            (clk),
        .reset          (reset),
        .dmem_addr      (dmem_addr),
        .dmem_data      (dmem_data),
        .dmem_wen       (dmem_wen),
        .host_req_valid (host_req_valid),
        .host_req_ready (host_req_ready),
        .host_req_op    (host_req_op),
        .host_req_addr  (host_req_addr),
        .host_req_wdata (host_req_wdata),
        .host_rsp_valid (host_rsp_valid),
        .host_rsp_ready (host_rsp_ready),
        .host_rsp_data  (host_rsp_data),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic core_store(input logic [31:0] a, input logic [31:0] d);
        dmem_wen   = 1'b1;
        dmem_addr  = a;
        core_wdata = d;
        step();
        dmem_wen   = 1'b0;
    endtask

    task automatic core_load(input string nm, input logic [31:0] a, input logic [31:0] exp);
        dmem_wen  = 1'b0;
        dmem_addr = a;
        #1;
        chk(nm, dmem_data, exp);
    endtask

    // Present a request until accepted; returns at acceptance edge + 1.
    task automatic host_req(input logic [1:0] op, input logic [4:0] a,
                            input logic [31:0] d, output int waits);
        host_req_valid = 1'b1;
        host_req_op    = op;
        host_req_addr  = a;
        host_req_wdata = d;
        waits = 0;
        #1;
        while (!host_req_ready && waits < 20) begin
            step();
            waits++;
        end
        if (!host_req_ready) begin
            checks++;
            errors++;
            $display("FAIL host_req_timeout: got ready=0 expected ready=1");
        end
        @(posedge clk);
        #1;
        host_req_valid = 1'b0;
    endtask

    task automatic host_txn(input logic [1:0] op, input logic [4:0] a,
                            input logic [31:0] d, input logic [31:0] exp,
                            input string nm);
        int w;
        host_req(op, a, d, w);
        chk({nm, "_wait"}, 32'(w), 32'd0);
        chk({nm, "_valid"}, {31'd0, host_rsp_valid}, 32'd1);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
        chk({nm, "_data"}, host_rsp_data, exp);
        step();
        chk({nm, "_idle_valid"}, {31'd0, host_rsp_valid}, 32'd0);
        chk({nm, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        vec_t vecs[9];
        int   w;
        int   steps;

        vecs[0] = '{1'b1, 32'h0000_0005, 32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 32'h0000_0005, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'h0000_0025, 32'h0123_4567};
        vecs[3] = '{1'b0, 32'h0000_0005, 32'h0123_4567};
        vecs[4] = '{1'b1, 32'h0000_0000, 32'h1111_1111};
        vecs[5] = '{1'b1, 32'h0000_001F, 32'h2222_2222};
        vecs[6] = '{1'b0, 32'h0000_0000, 32'h1111_1111};
        vecs[7] = '{1'b0, 32'h0000_001F, 32'h2222_2222};
        vecs[8] = '{1'b0, 32'hFFFF_FFE5, 32'h0123_4567};

        reset          = 1'b1;
        dmem_addr      = '0;
        dmem_wen       = 1'b0;
        core_wdata     = '0;
        host_req_valid = 1'b0;
        host_req_op    = 2'b11;
        host_req_addr  = '0;
        host_req_wdata = '0;
        host_rsp_ready = 1'b1;

        step();
        step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, host_rsp_valid}, 32'd0);
        chk("rst_ready", {31'd0, host_req_ready}, 32'd0);
        chk("rst_data", host_rsp_data, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, host_req_ready}, 32'd1);

        for (int i = 0; i < 9; i++) begin
            dmem_wen   = vecs[i].wen;
            dmem_addr  = vecs[i].addr;
            core_wdata = vecs[i].data;
            #1;
            chk($sformatf("vec%0d_bus", i), dmem_data, vecs[i].data);
            if (vecs[i].wen)
                chk($sformatf("vec%0d_ready", i), {31'd0, host_req_ready}, 32'd0);
            step();
        end
        dmem_wen = 1'b0;

        host_txn(2'b01, 5'd7, 32'h1234_5678, 32'h1234_5678, "hwrite7");
        host_txn(2'b00, 5'd7, 32'h0, 32'h1234_5678, "hread7");
        core_load("core_ld7", 32'd7, 32'h1234_5678);
        host_txn(2'b11, 5'd7, 32'hFFFF_FFFF, 32'h0, "hnop");
        host_txn(2'b00, 5'd5, 32'h0, 32'h0123_4567, "hread5");

        // Host write contending with a core store to addr 3.
        dmem_wen       = 1'b1;
        dmem_addr      = 32'd3;
        core_wdata     = 32'hAAAA_0000;
        host_req_valid = 1'b1;
        host_req_op    = 2'b01;
        host_req_addr  = 5'd4;
        host_req_wdata = 32'h4444_0000;
        #1;
        chk("cont_ready_low", {31'd0, host_req_ready}, 32'd0);
        step();
        dmem_wen = 1'b0;
        #1;
        chk("cont_ready_high", {31'd0, host_req_ready}, 32'd1);
        step();
        host_req_valid = 1'b0;
        chk("cont_rsp_valid", {31'd0, host_rsp_valid}, 32'd1);
        chk("cont_rsp_data", host_rsp_data, 32'h4444_0000);
        step();
        core_load("cont_ld3", 32'd3, 32'hAAAA_0000);
        core_load("cont_ld4", 32'd4, 32'h4444_0000);

        // Clear with a core store stalling the sweep.
        for (int i = 0; i < 32; i++) core_store(32'(i), 32'hFFFF_FFFF);
        host_req(2'b10, 5'd0, 32'h0, w);
        chk("clr_busy", {31'd0, busy}, 32'd1);
        step();
        step();
        step();
        core_store(32'd31, 32'h0000_0055);
        core_load("clr_ld31_mid", 32'd31, 32'h0000_0055);
        steps = 4;
        while (!host_rsp_valid && steps < 100) begin
            step();
            steps++;
        end
        chk("clr_latency", 32'(steps + 1), 32'd34);
        chk("clr_rsp_data", host_rsp_data, 32'h0000_0020);
        step();
        chk("clr_idle", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 32; i++)
            core_load($sformatf("clr_word%0d", i), 32'(i), 32'h0);

        // Backpressure on a read response.
        host_txn(2'b01, 5'd9, 32'hCAFE_F00D, 32'hCAFE_F00D, "bp_wr");
        host_rsp_ready = 1'b0;
        host_req(2'b00, 5'd9, 32'h0, w);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) core_store(32'd9, 32'h0);
            #1;
            chk($sformatf("bp_valid%0d", c), {31'd0, host_rsp_valid}, 32'd1);
            chk($sformatf("bp_data%0d", c), host_rsp_data, 32'hCAFE_F00D);
            chk($sformatf("bp_ready%0d", c), {31'd0, host_req_ready}, 32'd0);
            if (c != 2) step();
        end
        host_rsp_ready = 1'b1;
        #1;
        chk("bp_hold_valid", {31'd0, host_rsp_valid}, 32'd1);
        step();
        chk("bp_done_valid", {31'd0, host_rsp_valid}, 32'd0);
        chk("bp_done_ready", {31'd0, host_req_ready}, 32'd1);

        // Reset partway through a clear.
        for (int i = 0; i < 32; i++) core_store(32'(i), 32'hA500_0000 | 32'(i));
        host_req(2'b10, 5'd0, 32'h0, w);
        for (int c = 0; c < 10; c++) step();
        reset = 1'b1;
        #1;
        chk("rmc_ready", {31'd0, host_req_ready}, 32'd0);
        step();
        reset = 1'b0;
        #1;
        chk("rmc_busy", {31'd0, busy}, 32'd0);
        chk("rmc_valid", {31'd0, host_rsp_valid}, 32'd0);
        for (int i = 0; i < 32; i++)
            core_load($sformatf("rmc_word%0d", i), 32'(i),
                      (i < 10) ? 32'h0 : (32'hA500_0000 | 32'(i)));
        step();
        chk("rmc_still_idle", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
